axis_packet_source: RTL and testbench
=====================================

// Module: axis_packet_source
// PURPOSE
//  Configurable AXI-Stream packet transmitter feeding s_axis of axis_multiplexer; replaces ad-hoc bench stimulus.
//  Emits cfg_num_pkts packets of cfg_pkt_len beats each, with a programmable idle gap between packets and selectable data patterns.
//  Fully honours tready backpressure, and reports progress counters for datapath bring-up and throughput runs.
// PARAMETERS
//  DATA_WIDTH  32  tdata width (>=32)
//  LEN_WIDTH   16  width of packet-length config
//  CNT_WIDTH   16  width of packet-count config/status
//  GAP_WIDTH    8  width of inter-packet gap config
// PORTS
//  clk           in   1           system clock, all logic on rising edge
//  rst_n         in   1           asynchronous active-low reset
//  start         in   1           begin run; sampled only in IDLE
//  abort         in   1           terminate run cleanly (see BEHAVIOUR)
//  cfg_pkt_len   in   LEN_WIDTH   beats per packet; 0 treated as 1
//  cfg_num_pkts  in   CNT_WIDTH   packets per run; 0 = empty run
//  cfg_gap       in   GAP_WIDTH   idle cycles between packets
//  cfg_mode      in   2           00 const seed, 01 increment, 10 LFSR, 11 seed/~seed alternate
//  cfg_seed      in   DATA_WIDTH  pattern seed
//  m_axis_tdata  out  DATA_WIDTH  stream data
//  m_axis_tvalid out  1           stream valid
//  m_axis_tready in   1           stream ready from sink
//  m_axis_tlast  out  1           last beat of packet
//  busy          out  1           high in any state but IDLE
//  done          out  1           1-cycle pulse at run end
//  pkt_count     out  CNT_WIDTH   packets completed this run (tlast handshakes)
//  beat_count    out  32          beats handshaked this run (wraps)
// BEHAVIOUR
//  Reset (async assert, sync deassert): state IDLE; tvalid/tlast/busy/done=0; tdata=0; counts=0.
//  All outputs registered. Config latched on start; changes mid-run ignored.
//  FSM: IDLE -start-> LOAD -> SEND <-> GAP -> DONE -> IDLE.
//   IDLE: start=1 clears counts, latches cfg; goes to DONE if cfg_num_pkts==0, else LOAD.
//   LOAD: one cycle to prime the pattern; first tvalid rises 2 cycles after start sampled.
//   SEND: tvalid=1; beat advances only on tvalid&&tready; with tready held high, 1 beat/clk.
//         tlast=1 on beat cfg_pkt_len-1; a tlast handshake increments pkt_count.
//         After tlast: last packet -> DONE; cfg_gap==0 -> next packet back-to-back in SEND;
//         otherwise GAP.
//   GAP: tvalid=0 for exactly cfg_gap cycles after the tlast handshake cycle, then SEND.
//   DONE: done=1 for one cycle, busy=1; then IDLE.
//  AXIS rules: once tvalid=1, tdata/tlast/tvalid stay unchanged until handshake; tvalid never waits on tready.
//  Patterns advance per handshaked beat and continue across packets (not restarted per packet):
//   01: seed, seed+1, ... modulo 2^DATA_WIDTH.
//   10: 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1; zero seed forced to 1; zero-extended to DATA_WIDTH.
//   11: seed on even global beat index, ~seed on odd.
//  abort (level, sampled each clk):
//   - In SEND with the current beat not last: that beat completes normally; the next beat is forced tlast=1; then DONE.
//   - If the current beat already has tlast: run ends after its handshake.
//   - In LOAD/GAP: go to DONE next cycle with no further beats.
//   - In IDLE: ignored. abort with start in IDLE: start wins; abort acts from the next cycle.
//  start while busy: ignored. pkt_count/beat_count hold their values after DONE until the next start.
// TESTING
//  1 len=4,num=1,mode=01,seed=0x10,tready=1 -> tdata 0x10..0x13 on 4 consecutive clks, tlast on 0x13, done pulse, pkt=1, beats=4.
//  2 len=3, tready pattern 1,0,1,0.. -> tdata/tlast held stable during stalls; exactly 3 handshakes.
//  3 num=3,len=2,gap=2 -> tvalid low exactly 2 clks between packets; 6 beats; pkt_count=3.
//  4 len=8,mode=10,seed=0, abort during beat 2 -> beat 3 carries tlast; done; pkt=1, beats=4; first beat 0x1.
//  5 rst_n low mid-packet, tvalid=1 -> tvalid/tlast/busy drop to 0 without a clock edge; counts 0.
//  6 num=0 -> done 1 clk after start, tvalid never high; len=0,num=1 -> single beat with tlast=1.

Source files
------------

// File: rtl/axis_packet_source_if.sv
// AXI-Stream master/slave bundle used by the packet source.
// The source drives tdata/tvalid/tlast and receives tready from the sink.
interface axis_packet_source_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_packet_source.sv
// Configurable AXI-Stream packet transmitter.
// Emits a run of fixed-length packets with an optional idle gap between
// packets and a selectable data pattern. Honours tready backpressure and
// reports packet/beat progress counters. All outputs are registered.
module axis_packet_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
  input  logic [CNT_WIDTH-1:0]   cfg_num_pkts,
  input  logic [GAP_WIDTH-1:0]   cfg_gap,
  input  logic [1:0]             cfg_mode,
  input  logic [DATA_WIDTH-1:0]  cfg_seed,
  axis_packet_source_if.master   m_axis,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [31:0]            beat_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0]            MODE_CONST = 2'b00;
  localparam logic [1:0]            MODE_INCR  = 2'b01;
  localparam logic [1:0]            MODE_LFSR  = 2'b10;
  localparam logic [1:0]            MODE_ALT   = 2'b11;
  localparam logic [31:0]           LFSR_MASK  = 32'h8020_0003;
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO   = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]  GAP_ZERO   = {GAP_WIDTH{1'b0}};
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE    = GAP_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE   = DATA_WIDTH'(1);

  // One step of the right-shifting Galois LFSR for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    logic [31:0] res;
    if (cur[0]) begin
      res = (cur >> 1) ^ LFSR_MASK;
    end else begin
      res = cur >> 1;
    end
    return res;
  endfunction

  // Zero-extend a 32-bit LFSR value to the bus width.
  function automatic logic [DATA_WIDTH-1:0] widen32(input logic [31:0] v);
    logic [DATA_WIDTH-1:0] res;
    res       = {DATA_WIDTH{1'b0}};
    res[31:0] = v;
    return res;
  endfunction

  // Pattern value of the very first beat of a run.
  function automatic logic [DATA_WIDTH-1:0] first_pattern(input logic [1:0]            mode,
                                                          input logic [DATA_WIDTH-1:0] seed);
    logic [DATA_WIDTH-1:0] res;
    case (mode)
      MODE_LFSR: res = widen32((seed[31:0] == 32'd0) ? 32'd1 : seed[31:0]);
      default:   res = seed;
    endcase
    return res;
  endfunction

  // Pattern value following cur; next_odd is the parity of the next global beat index.
  function automatic logic [DATA_WIDTH-1:0] next_pattern(input logic [DATA_WIDTH-1:0] cur,
                                                         input logic [1:0]            mode,
                                                         input logic [DATA_WIDTH-1:0] seed,
                                                         input logic                  next_odd);
    logic [DATA_WIDTH-1:0] res;
    case (mode)
      MODE_CONST: res = seed;
      MODE_INCR:  res = cur + DATA_ONE;
      MODE_LFSR:  res = widen32(lfsr_next(cur[31:0]));
      MODE_ALT:   res = next_odd ? ~seed : seed;
      default:    res = seed;
    endcase
    return res;
  endfunction

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   last_idx_q, last_idx_d;
  logic [CNT_WIDTH-1:0]   num_q, num_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [1:0]             mode_q, mode_d;
  logic [DATA_WIDTH-1:0]  seed_q, seed_d;
  logic [LEN_WIDTH-1:0]   beat_idx_q, beat_idx_d;
  logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   abort_pend_q, abort_pend_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   pkt_count_q, pkt_count_d;
  logic [31:0]            beat_count_q, beat_count_d;

  logic                   hs_s;
  logic [CNT_WIDTH-1:0]   pkt_inc_s;
  logic [LEN_WIDTH-1:0]   beat_idx_inc_s;

  assign hs_s           = tvalid_q & m_axis.tready;
  assign pkt_inc_s      = pkt_count_q + CNT_ONE;
  assign beat_idx_inc_s = beat_idx_q + LEN_ONE;

  // Next-state, config latch, beat presentation and counter logic.
  always_comb begin
    state_d      = state_q;
    last_idx_d   = last_idx_q;
    num_d        = num_q;
    gap_d        = gap_q;
    mode_d       = mode_q;
    seed_d       = seed_q;
    beat_idx_d   = beat_idx_q;
    gap_cnt_d    = gap_cnt_q;
    abort_pend_d = abort_pend_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    pkt_count_d  = pkt_count_q;
    beat_count_d = beat_count_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A zero length is treated as a single-beat packet.
          last_idx_d   = (cfg_pkt_len == LEN_ZERO) ? LEN_ZERO : (cfg_pkt_len - LEN_ONE);
          num_d        = cfg_num_pkts;
          gap_d        = cfg_gap;
          mode_d       = cfg_mode;
          seed_d       = cfg_seed;
          pkt_count_d  = CNT_ZERO;
          beat_count_d = 32'd0;
          beat_idx_d   = LEN_ZERO;
          abort_pend_d = 1'b0;
          tvalid_d     = 1'b0;
          tlast_d      = 1'b0;
          if (cfg_num_pkts == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_SEND;
          tdata_d    = first_pattern(mode_q, seed_q);
          tvalid_d   = 1'b1;
          tlast_d    = (last_idx_q == LEN_ZERO);
          beat_idx_d = LEN_ZERO;
        end
      end

      ST_SEND: begin
        // Remember an abort seen at any point while this beat waits for tready.
        abort_pend_d = abort_pend_q | abort;
        if (hs_s) begin
          beat_count_d = beat_count_q + 32'd1;
          // Pattern runs on across packets; the next global index has opposite parity.
          tdata_d      = next_pattern(tdata_q, mode_q, seed_q, ~beat_count_q[0]);
          if (tlast_q) begin
            pkt_count_d = pkt_inc_s;
            if (abort || abort_pend_q || (pkt_inc_s == num_q)) begin
              state_d      = ST_DONE;
              tvalid_d     = 1'b0;
              tlast_d      = 1'b0;
              abort_pend_d = 1'b0;
            end else if (gap_q == GAP_ZERO) begin
              state_d    = ST_SEND;
              beat_idx_d = LEN_ZERO;
              tlast_d    = (last_idx_q == LEN_ZERO);
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q - GAP_ONE;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
            end
          end else begin
            // An abort turns the following beat into the final one of the run.
            state_d    = ST_SEND;
            beat_idx_d = beat_idx_inc_s;
            tlast_d    = (beat_idx_inc_s == last_idx_q) || abort || abort_pend_q;
          end
        end else begin
          state_d = ST_SEND;
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (gap_cnt_q == GAP_ZERO) begin
          state_d    = ST_SEND;
          tvalid_d   = 1'b1;
          beat_idx_d = LEN_ZERO;
          tlast_d    = (last_idx_q == LEN_ZERO);
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_idx_q   <= LEN_ZERO;
      num_q        <= CNT_ZERO;
      gap_q        <= GAP_ZERO;
      mode_q       <= 2'b00;
      seed_q       <= {DATA_WIDTH{1'b0}};
      beat_idx_q   <= LEN_ZERO;
      gap_cnt_q    <= GAP_ZERO;
      abort_pend_q <= 1'b0;
      tdata_q      <= {DATA_WIDTH{1'b0}};
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pkt_count_q  <= CNT_ZERO;
      beat_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_idx_q   <= last_idx_d;
      num_q        <= num_d;
      gap_q        <= gap_d;
      mode_q       <= mode_d;
      seed_q       <= seed_d;
      beat_idx_q   <= beat_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      abort_pend_q <= abort_pend_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pkt_count_q  <= pkt_count_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_count     = pkt_count_q;
  assign beat_count    = beat_count_q;

endmodule

// File: tb/tb_axis_packet_source.sv
// Self-checking bench for axis_packet_source: directed table of runs,
// hand-written abort/reset sequences and randomized runs, all compared
// against a beat-list reference model built from the pattern rules.
module tb_axis_packet_source;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 16;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [LW-1:0] cfg_pkt_len;
  logic [CW-1:0] cfg_num_pkts;
  logic [GW-1:0] cfg_gap;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_seed;
  logic          busy;
  logic          done;
  logic [CW-1:0] pkt_count;
  logic [31:0]   beat_count;

  axis_packet_source_if #(.DATA_WIDTH(DW)) axis ();

  axis_packet_source #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW), .GAP_WIDTH(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_pkt_len(cfg_pkt_len), .cfg_num_pkts(cfg_num_pkts), .cfg_gap(cfg_gap),
    .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .m_axis(axis),
    .busy(busy), .done(done), .pkt_count(pkt_count), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  // abort_kind: 0 none, 1 raised while beat abort_at is presented, 2 raised in first gap
  // ready_mode: 0 always ready, 1 alternate, 2 random
  typedef struct {
    int          len;
    int          num;
    int          gap;
    int          mode;
    logic [31:0] seed;
    int          ready_mode;
    int          abort_kind;
    int          abort_at;
    int          exp_pkts;
    int          exp_beats;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_data[$];
  bit          exp_last[$];
  int          mdl_pkts;
  int          mdl_beats;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Reference model: full list of beats the run should emit.
  function automatic void build_model(input vec_t v);
    int          L;
    int          full;
    int          T;
    logic [31:0] lf;
    logic [31:0] d;
    bit          last;
    exp_data.delete();
    exp_last.delete();
    L    = (v.len == 0) ? 1 : v.len;
    full = L * v.num;
    T    = full;
    if (v.abort_kind == 1 && v.abort_at < full)
      T = ((v.abort_at % L) == L - 1) ? v.abort_at + 1 : v.abort_at + 2;
    if (v.abort_kind == 2 && v.num > 1 && v.gap > 0)
      T = L;
    lf       = (v.seed == 32'd0) ? 32'd1 : v.seed;
    mdl_pkts = 0;
    for (int i = 0; i < T; i++) begin
      case (v.mode)
        0:       d = v.seed;
        1:       d = v.seed + 32'(i);
        2:       begin d = lf; lf = lfsr_step(lf); end
        default: d = ((i % 2) == 1) ? ~v.seed : v.seed;
      endcase
      last = ((i % L) == L - 1) || (i == T - 1);
      if (last) mdl_pkts++;
      exp_data.push_back(d);
      exp_last.push_back(last);
    end
    mdl_beats = T;
  endfunction

  task automatic run_vec(input vec_t v, input int exp_pkts, input int exp_beats, input string tag);
    int cyc;
    int beat_i;
    int gap_run;
    int first_cyc;
    int last_hs_cyc;
    int L;
    bit after_last;
    bit got_done;
    bit hs;
    L = (v.len == 0) ? 1 : v.len;
    first_cyc = -1; last_hs_cyc = -1; beat_i = 0; gap_run = 0;
    after_last = 1'b0; got_done = 1'b0;
    @(negedge clk);
    cfg_pkt_len  = v.len[LW-1:0];
    cfg_num_pkts = v.num[CW-1:0];
    cfg_gap      = v.gap[GW-1:0];
    cfg_mode     = v.mode[1:0];
    cfg_seed     = v.seed;
    start        = 1'b1;
    abort        = 1'b0;
    axis.tready  = 1'b0;
    @(negedge clk);
    start        = 1'b0;
    // Config changes during the run must have no effect.
    cfg_pkt_len  = 16'($urandom);
    cfg_num_pkts = 16'($urandom);
    cfg_gap      = 8'($urandom);
    cfg_mode     = 2'($urandom);
    cfg_seed     = $urandom;
    check({tag, "/busy_after_start"}, busy, 1);
    cyc = 1;
    while (!got_done && cyc < 4000) begin
      if (done) begin
        got_done = 1'b1;
        check({tag, "/tvalid_at_done"}, axis.tvalid, 0);
        if (v.num == 0) check({tag, "/done_latency"}, cyc, 1);
      end else begin
        if (axis.tvalid) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (beat_i < exp_data.size()) begin
            check({tag, "/tdata"}, axis.tdata, exp_data[beat_i]);
            check({tag, "/tlast"}, axis.tlast, exp_last[beat_i]);
          end else begin
            check({tag, "/extra_beat"}, beat_i, exp_data.size());
          end
          if (after_last) begin
            check({tag, "/gap_len"}, gap_run, v.gap);
            after_last = 1'b0;
          end
        end else if (after_last) begin
          gap_run++;
        end
        case (v.ready_mode)
          0:       axis.tready = 1'b1;
          1:       axis.tready = ((cyc % 2) == 0);
          default: axis.tready = 1'($urandom_range(0, 1));
        endcase
        if (v.abort_kind == 1 && axis.tvalid && beat_i == v.abort_at) abort = 1'b1;
        if (v.abort_kind == 2 && after_last && !axis.tvalid && beat_i == L) abort = 1'b1;
        hs = axis.tvalid && axis.tready;
        if (hs) begin
          if (beat_i < exp_last.size() && exp_last[beat_i]) begin
            after_last = 1'b1;
            gap_run    = 0;
          end
          last_hs_cyc = cyc;
          beat_i++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) check({tag, "/done_timeout"}, 0, 1);
    check({tag, "/handshakes"}, beat_i, exp_beats);
    if (v.num > 0 && exp_beats > 0) check({tag, "/first_tvalid_latency"}, first_cyc, 2);
    if (v.ready_mode == 0 && v.gap == 0 && v.abort_kind == 0 && exp_beats > 0)
      check({tag, "/stream_cycles"}, last_hs_cyc - first_cyc, exp_beats - 1);
    abort       = 1'b0;
    axis.tready = 1'b0;
    @(negedge clk);
    check({tag, "/done_pulse_width"}, done, 0);
    check({tag, "/busy_after_done"}, busy, 0);
    check({tag, "/pkt_count"}, pkt_count, exp_pkts);
    check({tag, "/beat_count"}, beat_count, exp_beats);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_pkt_len = '0; cfg_num_pkts = '0; cfg_gap = '0; cfg_mode = 2'b00; cfg_seed = '0;
    axis.tready = 1'b0;

    tbl[0] = '{4, 1, 0, 1, 32'h10,       0, 0, 0, 1, 4};
    tbl[1] = '{3, 1, 0, 1, 32'h100,      1, 0, 0, 1, 3};
    tbl[2] = '{2, 3, 2, 0, 32'hA5A5,     0, 0, 0, 3, 6};
    tbl[3] = '{8, 1, 0, 2, 32'h0,        0, 1, 2, 1, 4};
    tbl[4] = '{4, 0, 0, 1, 32'h55,       0, 0, 0, 0, 0};
    tbl[5] = '{0, 1, 0, 3, 32'h1234,     0, 0, 0, 1, 1};
    tbl[6] = '{3, 2, 0, 3, 32'hF0F0F0F0, 1, 0, 0, 2, 6};
    tbl[7] = '{2, 3, 3, 1, 32'h7,        0, 2, 0, 1, 2};
    tbl[8] = '{3, 2, 1, 2, 32'hDEADBEEF, 2, 1, 2, 1, 3};

    // Reset state.
    #12;
    check("reset/tvalid", axis.tvalid, 0);
    check("reset/tlast", axis.tlast, 0);
    check("reset/tdata", axis.tdata, 0);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/pkt_count", pkt_count, 0);
    check("reset/beat_count", beat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      build_model(tbl[i]);
      run_vec(tbl[i], tbl[i].exp_pkts, tbl[i].exp_beats, $sformatf("vec%0d", i));
    end

    // Abort together with start: start wins, abort then ends the run from LOAD.
    @(negedge clk);
    cfg_pkt_len = 16'd4; cfg_num_pkts = 16'd2; cfg_gap = 8'd0; cfg_mode = 2'b01; cfg_seed = 32'h0;
    start = 1'b1; abort = 1'b1; axis.tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_abort/busy", busy, 1);
    check("load_abort/tvalid_load", axis.tvalid, 0);
    @(negedge clk);
    check("load_abort/done", done, 1);
    check("load_abort/tvalid_done", axis.tvalid, 0);
    abort = 1'b0;
    @(negedge clk);
    check("load_abort/idle_busy", busy, 0);
    check("load_abort/beat_count", beat_count, 0);
    check("load_abort/pkt_count", pkt_count, 0);

    // Asynchronous reset in the middle of a packet.
    @(negedge clk);
    cfg_pkt_len = 16'd8; cfg_num_pkts = 16'd2; cfg_gap = 8'd0; cfg_mode = 2'b01; cfg_seed = 32'h0;
    start = 1'b1; axis.tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("rst_mid/tvalid_before", axis.tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid/tvalid", axis.tvalid, 0);
    check("rst_mid/tlast", axis.tlast, 0);
    check("rst_mid/busy", busy, 0);
    check("rst_mid/beat_count", beat_count, 0);
    check("rst_mid/pkt_count", pkt_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    axis.tready = 1'b0;
    @(negedge clk);

    // Randomized runs against the reference model.
    for (int r = 0; r < 25; r++) begin
      rv.len        = int'($urandom_range(0, 5));
      rv.num        = int'($urandom_range(0, 3));
      rv.gap        = int'($urandom_range(0, 3));
      rv.mode       = int'($urandom_range(0, 3));
      rv.seed       = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rv.ready_mode = 2;
      rv.abort_kind = int'($urandom_range(0, 2));
      rv.abort_at   = int'($urandom_range(0, 10));
      rv.exp_pkts   = 0;
      rv.exp_beats  = 0;
      build_model(rv);
      run_vec(rv, mdl_pkts, mdl_beats, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
